// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode, control-field encodings and control-word types shared by the RV32I pipeline
package riscv_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Control fields that travel down the pipeline into execute
  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
    logic       alu_src;
  } ex_ctrl_t;

  // Full decoded control word; imm_src is consumed inside decode only
  typedef struct packed {
    ex_ctrl_t   ex;
    logic [1:0] imm_src;
  } ctrl_t;

endpackage

// File: rtl/register_file.sv
// register_file: 32x32 register file, two combinational read ports with writeback bypass, async clear
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1_i,
  input  logic [AW-1:0]   ra2_i,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  input  logic            we_i,
  input  logic [AW-1:0]   wa_i,
  input  logic [XLEN-1:0] wd_i
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic            wr_en;

  // x0 is hardwired, so a write aimed at it never happens
  assign wr_en = we_i && (wa_i != '0);

  // Entries clear on reset; otherwise the writeback port updates one entry per edge
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    else if (wr_en)
      regs_q[wa_i] <= wd_i;
  end

  // Bypass the in-flight writeback so decode sees the value being written this cycle
  assign rd1_o = (ra1_i == '0) ? '0 : (wr_en && wa_i == ra1_i) ? wd_i : regs_q[ra1_i];
  assign rd2_o = (ra2_i == '0) ? '0 : (wr_en && wa_i == ra2_i) ? wd_i : regs_q[ra2_i];

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: RV32I decode stage - control decode, register read, immediate extend, ID/EX register
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            FlushE,
  input  logic            RegWriteW,
  input  logic [4:0]      RdW,
  input  logic [XLEN-1:0] ResultW,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
);

  typedef struct packed {
    ex_ctrl_t        ctrl;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
  } idex_t;

  logic [6:0]      op;
  logic [2:0]      f3;
  logic            f7b5;
  logic            alu_ok;
  logic [2:0]      alu_ctl;
  ctrl_t           ctrl_d;
  logic [XLEN-1:0] rd1, rd2, imm_ext;
  idex_t           idex_d, idex_q;

  assign op   = InstrD[6:0];
  assign f3   = InstrD[14:12];
  assign f7b5 = InstrD[30];

  register_file #(.XLEN(XLEN), .NREGS(NREGS), .AW(5)) u_rf (
    .clk   (clk),
    .rst   (rst),
    .ra1_i (InstrD[19:15]),
    .ra2_i (InstrD[24:20]),
    .rd1_o (rd1),
    .rd2_o (rd2),
    .we_i  (RegWriteW),
    .wa_i  (RdW),
    .wd_i  (ResultW)
  );

  // ALU decoder: only R-type uses funct7[5] to select subtract; I-ALU always adds on funct3=000
  always_comb begin
    alu_ok  = f3 inside {F3_ADD, F3_SLT, F3_OR, F3_AND};
    alu_ctl = (f3 == F3_SLT) ? ALU_SLT :
              (f3 == F3_OR)  ? ALU_OR  :
              (f3 == F3_AND) ? ALU_AND :
              (op == OP_R && f7b5) ? ALU_SUB : ALU_ADD;
  end

  // Main decoder: unknown opcodes and unsupported funct3 leave the all-zero word, i.e. a bubble
  always_comb begin
    ctrl_d = '0;
    case (op)
      OP_R: if (alu_ok) begin
        ctrl_d.ex.reg_write   = 1'b1;
        ctrl_d.ex.alu_control = alu_ctl;
      end
      OP_I: if (alu_ok) begin
        ctrl_d.ex.reg_write   = 1'b1;
        ctrl_d.ex.alu_src     = 1'b1;
        ctrl_d.ex.alu_control = alu_ctl;
      end
      OP_LW: if (f3 == F3_W) begin
        ctrl_d.ex.reg_write  = 1'b1;
        ctrl_d.ex.alu_src    = 1'b1;
        ctrl_d.ex.result_src = RES_MEM;
      end
      OP_SW: if (f3 == F3_W) begin
        ctrl_d.ex.mem_write = 1'b1;
        ctrl_d.ex.alu_src   = 1'b1;
        ctrl_d.imm_src      = IMM_S;
      end
      OP_BEQ: if (f3 == F3_BEQ) begin
        ctrl_d.ex.branch      = 1'b1;
        ctrl_d.ex.alu_control = ALU_SUB;
        ctrl_d.imm_src        = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.ex.reg_write  = 1'b1;
        ctrl_d.ex.jump       = 1'b1;
        ctrl_d.ex.result_src = RES_PC4;
        ctrl_d.imm_src       = IMM_J;
      end
      default: ;
    endcase
  end

  // Sign-extend the immediate; I-format doubles as the don't-care value for R-type and bubbles
  always_comb begin
    imm_ext = (ctrl_d.imm_src == IMM_S) ? {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]} :
              (ctrl_d.imm_src == IMM_B) ? {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0} :
              (ctrl_d.imm_src == IMM_J) ? {{(XLEN-20){InstrD[31]}}, InstrD[19:12], InstrD[20], InstrD[30:21], 1'b0} :
                                          {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
  end

  assign idex_d = '{
    ctrl: ctrl_d.ex,
    rd1:  rd1,
    rd2:  rd2,
    imm:  imm_ext,
    rd:   InstrD[11:7],
    rs1:  InstrD[19:15],
    rs2:  InstrD[24:20],
    pc:   PCD,
    pc4:  PCPlus4D
  };

  // ID/EX register loads every cycle; a flush from execute turns this slot into a bubble
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      idex_q <= '0;
    else
      idex_q <= FlushE ? '0 : idex_d;
  end

  assign RegWriteE   = idex_q.ctrl.reg_write;
  assign ResultSrcE  = idex_q.ctrl.result_src;
  assign MemWriteE   = idex_q.ctrl.mem_write;
  assign JumpE       = idex_q.ctrl.jump;
  assign BranchE     = idex_q.ctrl.branch;
  assign ALUControlE = idex_q.ctrl.alu_control;
  assign ALUSrcE     = idex_q.ctrl.alu_src;
  assign RD1E        = idex_q.rd1;
  assign RD2E        = idex_q.rd2;
  assign ImmExtE     = idex_q.imm;
  assign RdE         = idex_q.rd;
  assign Rs1E        = idex_q.rs1;
  assign Rs2E        = idex_q.rs2;
  assign PCE         = idex_q.pc;
  assign PCPlus4E    = idex_q.pc4;

endmodule

// File: tb/tb_decode_cycle.sv
// tb_decode_cycle: directed vector table, corner sequences and random stimulus against a reference model
module tb_decode_cycle;

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] InstrD = '0, PCD = '0, PCPlus4D = '0, ResultW = '0;
  logic        FlushE = 1'b0, RegWriteW = 1'b0;
  logic [4:0]  RdW = '0;
  logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  RdE, Rs1E, Rs2E;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .FlushE(FlushE),
    .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .JumpE(JumpE),
    .BranchE(BranchE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic        mw, j, b;
    logic [2:0]  aluc;
    logic        asrc;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] pc, pc4;
  } out_t;

  // ctl = {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch, ALUControl[2:0], ALUSrc}
  typedef struct packed {
    logic [31:0] ins;
    logic        fl, we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [9:0]  ctl;
    logic [31:0] imm, rd1, rd2;
  } vec_t;

  out_t        act;
  vec_t        tbl [16];
  logic [31:0] mrf [32];
  logic [6:0]  ops [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
  logic [2:0]  f3s [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
  int          vectors = 0, miscompares = 0;

  assign act = {RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
                RD1E, RD2E, ImmExtE, RdE, Rs1E, Rs2E, PCE, PCPlus4E};

  task automatic check(input string nm, input out_t e);
    vectors++;
    if (act !== e) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, e);
    end
  endtask

  task automatic apply(input logic [31:0] ins, pc, input logic fl, we, input logic [4:0] wa, input logic [31:0] wd);
    @(negedge clk);
    InstrD = ins; PCD = pc; PCPlus4D = pc + 32'd4; FlushE = fl; RegWriteW = we; RdW = wa; ResultW = wd;
    @(posedge clk);
    #1;
  endtask

  // returns {supported, ALU operation} for an ALU-class funct3
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return {1'b1, sub ? 3'b001 : 3'b000};
      3'd2:    return 4'b1101;
      3'd6:    return 4'b1011;
      3'd7:    return 4'b1010;
      default: return 4'b0000;
    endcase
  endfunction

  // Reference model: architectural register array plus opcode rules; write lands before read (bypass)
  task automatic model(input logic [31:0] ins, pc, input logic fl, we, input logic [4:0] wa, input logic [31:0] wd, output out_t e);
    logic signed [31:0] s, t;
    logic [3:0]         a;
    logic [1:0]         fmt;
    logic [2:0]         f3;
    s = ins; f3 = ins[14:12]; fmt = 2'd0;
    if (we && wa != 5'd0) mrf[wa] = wd;
    e = '0;
    if (!fl) begin
      case (ins[6:0])
        7'h33: begin a = alu_of(f3, ins[30]); e.rw = a[3]; e.aluc = a[2:0]; end
        7'h13: begin a = alu_of(f3, 1'b0); e.rw = a[3]; e.asrc = a[3]; e.aluc = a[2:0]; end
        7'h03: if (f3 == 3'd2) begin e.rw = 1'b1; e.asrc = 1'b1; e.rs = 2'b01; end
        7'h23: if (f3 == 3'd2) begin e.mw = 1'b1; e.asrc = 1'b1; fmt = 2'd1; end
        7'h63: if (f3 == 3'd0) begin e.b = 1'b1; e.aluc = 3'b001; fmt = 2'd2; end
        7'h6F: begin e.rw = 1'b1; e.j = 1'b1; e.rs = 2'b10; fmt = 2'd3; end
        default: ;
      endcase
      case (fmt)
        2'd0: e.imm = s >>> 20;
        2'd1: begin t = s >>> 25; e.imm = (t << 5) | 32'(ins[11:7]); end
        2'd2: begin t = s >>> 31; e.imm = (t << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1); end
        default: begin t = s >>> 31; e.imm = (t << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1); end
      endcase
      e.rd1 = mrf[ins[19:15]];
      e.rd2 = mrf[ins[24:20]];
      e.rd  = ins[11:7];
      e.rs1 = ins[19:15];
      e.rs2 = ins[24:20];
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    out_t        e, m;
    logic [31:0] pc, ins, wd;
    logic [4:0]  wa;
    logic        fl, we;
    int          sel;
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    tbl[0]  = '{32'h00500093, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_00_000_000_1, 32'h5,        32'h0,        32'h0};
    tbl[1]  = '{32'h00000000, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF, 10'b0_00_000_000_0, 32'h0,        32'h0,        32'h0};
    tbl[2]  = '{32'h002081B3, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_00_000_000_0, 32'h2,        32'h0,        32'hDEADBEEF};
    tbl[3]  = '{32'h406302B3, 1'b0, 1'b1, 5'd6, 32'h7,        10'b1_00_000_001_0, 32'h406,      32'h7,        32'h7};
    tbl[4]  = '{32'h00000393, 1'b0, 1'b1, 5'd0, 32'h1234,     10'b1_00_000_000_1, 32'h0,        32'h0,        32'h0};
    tbl[5]  = '{32'h00000433, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_00_000_000_0, 32'h0,        32'h0,        32'h0};
    tbl[6]  = '{32'hFE20AE23, 1'b0, 1'b0, 5'd0, 32'h0,        10'b0_00_100_000_1, 32'hFFFFFFFC, 32'h0,        32'hDEADBEEF};
    tbl[7]  = '{32'hFE000CE3, 1'b0, 1'b0, 5'd0, 32'h0,        10'b0_00_001_001_0, 32'hFFFFFFF8, 32'h0,        32'h0};
    tbl[8]  = '{32'h001000EF, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_10_010_000_0, 32'h800,      32'h0,        32'h0};
    tbl[9]  = '{32'h00812203, 1'b1, 1'b0, 5'd0, 32'h0,        10'b0_00_000_000_0, 32'h0,        32'h0,        32'h0};
    tbl[10] = '{32'h00812203, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_01_000_000_1, 32'h8,        32'hDEADBEEF, 32'h0};
    tbl[11] = '{32'h0000007F, 1'b0, 1'b0, 5'd0, 32'h0,        10'b0_00_000_000_0, 32'h0,        32'h0,        32'h0};
    tbl[12] = '{32'h00048533, 1'b1, 1'b1, 5'd9, 32'h55,       10'b0_00_000_000_0, 32'h0,        32'h0,        32'h0};
    tbl[13] = '{32'h00048533, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_00_000_000_0, 32'h0,        32'h55,       32'h0};
    tbl[14] = '{32'h000010B3, 1'b0, 1'b0, 5'd0, 32'h0,        10'b0_00_000_000_0, 32'h0,        32'h0,        32'h0};
    tbl[15] = '{32'hFFF16593, 1'b0, 1'b0, 5'd0, 32'h0,        10'b1_00_000_011_1, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h0};
    // reset held with a valid addi on the decode inputs
    InstrD = 32'h00500093; PCD = 32'h40; PCPlus4D = 32'h44;
    #2 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("reset", '0);
    rst = 1'b1;
    // directed table; the first apply is the first edge after reset release
    for (int k = 0; k < 16; k++) begin
      pc = 32'h1000 + 32'(k) * 32'd8;
      model(tbl[k].ins, pc, tbl[k].fl, tbl[k].we, tbl[k].wa, tbl[k].wd, m);
      e = tbl[k].fl ? '0 : {tbl[k].ctl, tbl[k].rd1, tbl[k].rd2, tbl[k].imm,
                            tbl[k].ins[11:7], tbl[k].ins[19:15], tbl[k].ins[24:20], pc, pc + 32'd4};
      apply(tbl[k].ins, pc, tbl[k].fl, tbl[k].we, tbl[k].wa, tbl[k].wd);
      check($sformatf("tbl%0d", k), e);
    end
    // randomized instructions, flushes and writebacks (half aimed at rs1 to hit the bypass)
    for (int n = 0; n < 300; n++) begin
      ins = $urandom;
      sel = int'($urandom_range(0, 7));
      if (sel < 6) begin
        ins[6:0] = ops[sel];
        if ($urandom_range(0, 3) != 0)
          ins[14:12] = (sel < 2) ? f3s[$urandom_range(0, 3)] : (sel < 4) ? 3'd2 : 3'd0;
      end
      fl = ($urandom_range(0, 7) == 0);
      we = 1'($urandom_range(0, 1));
      wa = $urandom_range(0, 1) != 0 ? ins[19:15] : 5'($urandom);
      wd = $urandom;
      pc = $urandom & 32'hFFFFFFFC;
      model(ins, pc, fl, we, wa, wd, e);
      apply(ins, pc, fl, we, wa, wd);
      check($sformatf("rnd%0d", n), e);
    end
    // asynchronous reset mid-cycle clears outputs at once and empties the register file
    @(negedge clk);
    #2 rst = 1'b0; RegWriteW = 1'b0;
    #1 check("async_rst", '0);
    for (int i = 0; i < 32; i++) mrf[i] = '0;
    @(posedge clk);
    #1 rst = 1'b1;
    for (int r = 1; r < 4; r++) begin
      ins = {7'd0, 5'(r + 1), 5'(r), 3'd0, 5'(r + 10), 7'h33};
      model(ins, 32'h2000, 1'b0, 1'b0, 5'd0, 32'h0, e);
      apply(ins, 32'h2000, 1'b0, 1'b0, 5'd0, 32'h0);
      check($sformatf("post_rst%0d", r), e);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
